conversor_bin_bcd_seq: RTL and testbench

Sequential shift-and-add-3 (double-dabble) converter from unsigned binary to packed BCD. It sits directly upstream of the 7-segment decoders and downstream of the 8-bit RPN ALU result register. Each iteration applies the per-digit add-3 correction (digit >= 5 -> digit + 3) to every BCD nibble, then shifts the next binary bit in. Start/busy/done handshake, one bit per clock.

---
 rtl/conversor_bin_bcd_seq.sv | 108 ++++++++++
 tb/tb_conversor_bin_bcd_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/conversor_bin_bcd_seq.sv
// Sequential double-dabble converter: unsigned binary to packed BCD, one bit per clock.
// Define BCD_SINAL_EN to treat Entrada as two's complement and report the sign on Negativo.
module conversor_bin_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Inicio,
    input  logic [WIDTH-1:0]      Entrada,
    output logic                  Ocupado,
    output logic                  Pronto,
    output logic [4*DIGITS-1:0]   Saida,
    output logic                  Negativo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] bin_q;
    logic [BW-1:0]    acc_q;
    logic [BW-1:0]    acc_adj;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] load_val;

    // NOTE: combinational blocks assign a full default first so no path leaves a latch.
    always_comb begin
        acc_adj = acc_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5)
                acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
        end
    end

`ifdef BCD_SINAL_EN
    logic sign_in;
    logic sign_q;

    // Magnitude fits in WIDTH unsigned bits, including the most negative value.
    assign sign_in  = Entrada[WIDTH-1];
    assign load_val = sign_in ? (WIDTH'(0) - Entrada) : Entrada;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sign_q   <= 1'b0;
            Negativo <= 1'b0;
        end else begin
            if (state == IDLE && Inicio)
                sign_q <= sign_in;
            if (state == DONE)
                Negativo <= sign_q;
        end
    end
`else
    assign load_val = Entrada;
    assign Negativo = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            Ocupado <= 1'b0;
            Pronto  <= 1'b0;
            Saida   <= '0;
        end else begin
            Pronto <= 1'b0;
            case (state)
                IDLE: begin
                    if (Inicio) begin
                        bin_q   <= load_val;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        Ocupado <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    // Corrected digits shift up one bit; binary MSB enters the units digit.
                    acc_q <= BW'({acc_adj, bin_q[WIDTH-1]});
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        Ocupado <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    Saida  <= acc_q;
                    Pronto <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_bin_bcd_seq.sv
// Randomised scoreboard bench for conversor_bin_bcd_seq: driver pushes expectations,
// a negedge monitor pops them when Pronto appears and checks value and arrival cycle.
module tb_conversor_bin_bcd_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;

    typedef struct {
        logic [BW-1:0] saida;
        logic          neg;
        int            due;
    } exp_t;

    logic              Clock;
    logic              Reset_n;
    logic              Inicio;
    logic [WIDTH-1:0]  Entrada;
    logic              Ocupado;
    logic              Pronto;
    logic [BW-1:0]     Saida;
    logic              Negativo;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   busy_run = 0;
    exp_t sb[$];
    exp_t last_exp;

    conversor_bin_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Inicio  (Inicio),
        .Entrada (Entrada),
        .Ocupado (Ocupado),
        .Pronto  (Pronto),
        .Saida   (Saida),
        .Negativo(Negativo)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits of the value by plain division.
    function automatic exp_t model(input logic [WIDTH-1:0] v);
        exp_t        e;
        int unsigned mag;
        e.neg = 1'b0;
        mag   = v;
`ifdef BCD_SINAL_EN
        if (v[WIDTH-1]) begin
            e.neg = 1'b1;
            mag   = (1 << WIDTH) - int'(v);
        end
`endif
        e.saida = '0;
        for (int d = 0; d < DIGITS; d++) begin
            e.saida[4*d +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        e.due = 0;
        return e;
    endfunction

    // Issue one start, then scramble Inicio/Entrada until the converter can accept again.
    task automatic convert(input logic [WIDTH-1:0] v);
        exp_t e;
        Inicio  = 1'b1;
        Entrada = v;
        e       = model(v);
        e.due   = cyc + 1 + WIDTH + 1;
        sb.push_back(e);
        last_exp = e;
        @(negedge Clock);
        for (int k = 0; k < WIDTH + 1; k++) begin
            Inicio  = 1'($urandom_range(0, 1));
            Entrada = WIDTH'($urandom);
            @(negedge Clock);
        end
        Inicio = 1'b0;
    endtask

    always @(negedge Clock) begin
        if (!Reset_n) begin
            busy_run = 0;
        end else begin
            if (Pronto) begin
                if (sb.size() == 0) begin
                    check("pronto_unexpected", 32'(Pronto), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pronto_cycle", cyc, e.due);
                    check("saida", 32'(Saida), 32'(e.saida));
                    check("negativo", 32'(Negativo), 32'(e.neg));
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                check("pronto_missing", 32'(Pronto), 32'd1);
                void'(sb.pop_front());
            end
            if (Ocupado) begin
                busy_run++;
            end else if (busy_run != 0) begin
                check("ocupado_len", busy_run, WIDTH);
                busy_run = 0;
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] directed [6];
        int n;
        directed = '{8'h00, 8'hFF, 8'h63, 8'h80, 8'h0A, 8'h7F};

        Reset_n = 1'b0;
        Inicio  = 1'b0;
        Entrada = '0;
        repeat (3) @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);
        check("rst_saida", 32'(Saida), 32'd0);
        check("rst_pronto", 32'(Pronto), 32'd0);
        check("rst_ocupado", 32'(Ocupado), 32'd0);
        check("rst_negativo", 32'(Negativo), 32'd0);

        foreach (directed[i]) convert(directed[i]);

        for (int t = 0; t < 40; t++) begin
            convert(WIDTH'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge Clock);
        end

        // Inicio held high: a fresh conversion every WIDTH+2 cycles.
        Inicio  = 1'b1;
        Entrada = 8'h2A;
        n = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e     = model(8'h2A);
            e.due = n + k * (WIDTH + 2) + WIDTH + 1;
            sb.push_back(e);
        end
        repeat (3 * (WIDTH + 2)) @(negedge Clock);
        Inicio = 1'b0;

        // Result holds while idle and Entrada toggles.
        convert(8'hFF);
        for (int k = 0; k < 20; k++) begin
            Entrada = WIDTH'($urandom);
            @(negedge Clock);
            check("hold_saida", 32'(Saida), 32'(last_exp.saida));
            check("hold_pronto", 32'(Pronto), 32'd0);
        end

        // Reset in the middle of a conversion abandons it with no stale digits.
        Inicio  = 1'b1;
        Entrada = 8'hFF;
        @(negedge Clock);
        Inicio = 1'b0;
        repeat (4) @(negedge Clock);
        #2 Reset_n = 1'b0;
        #1;
        check("midrst_saida", 32'(Saida), 32'd0);
        check("midrst_ocupado", 32'(Ocupado), 32'd0);
        check("midrst_pronto", 32'(Pronto), 32'd0);
        check("midrst_negativo", 32'(Negativo), 32'd0);
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (WIDTH + 4) @(negedge Clock);
        check("postrst_saida", 32'(Saida), 32'd0);
        convert(8'h07);

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge Clock);
        check("drain", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
